// File: rtl/spi_slaveio.sv
// spi_slaveio: CPU-bus-mapped SPI responder (mode 0, MSB first).
//
// An external SPI master exchanges bytes with the CPU through a small
// register file: one TX byte buffer, one RX byte buffer, status flags,
// interrupt enables and a received-byte counter.
//
// Ports
//   clk, rst_n     system clock (rising edge), asynchronous active-low reset
//   AD, DI, DO     register address, CPU write data, read data (combinational from AD)
//   rw, cs         1=read/0=write, chip select (address decode qualified by vma)
//   irq            registered level interrupt, active high
//   ssel_n, sck    SPI slave select (active low) and clock from the master
//   mosi, miso     SPI serial data in / out
//   miso_oe        1 = drive the miso pin
//
// Register map
//   0 DATA   rd: rx_buf (clears rx_full)   wr: tx_buf (clears tx_empty)
//   1 STATUS {irq, 2'b0, ss_active, underrun, overrun, tx_empty, rx_full}
//   2 CTRL   b0 rx_ie, b1 tx_ie, b6 w1: clear overrun/underrun, b7 w1: flush tx
//   3 COUNT  rd: bytes received mod 256, wr: clear
//   4-7      read 8'h00
module spi_slaveio #(
    parameter logic [7:0]  IDLE_FILL   = 8'hFF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    output logic       irq,
    input  logic       ssel_n,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned SH_W   = BYTE_W - 1;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_CTRL   = 3'd2;
    localparam logic [2:0] ADDR_COUNT  = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers plus one delay stage for edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   ss_d;
    logic                   sck_d;
    logic                   ss_s;
    logic                   sck_s;
    logic                   mosi_s;
    logic                   ss_fall;
    logic                   sck_rise;
    logic                   sck_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync   <= '1;
            sck_sync  <= '0;
            mosi_sync <= '0;
            ss_d      <= 1'b1;
            sck_d     <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ssel_n};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            ss_d      <= ss_s;
            sck_d     <= sck_s;
        end
    end

    assign ss_s     = ss_sync[SYNC_STAGES-1];
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign ss_fall  = ss_d & ~ss_s;
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = sck_d & ~sck_s;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    state_t             state,     state_d;
    logic [BYTE_W-1:0]  rx_buf,    rx_buf_d;
    logic [BYTE_W-1:0]  tx_buf,    tx_buf_d;
    logic               rx_full,   rx_full_d;
    logic               tx_empty,  tx_empty_d;
    logic               overrun,   overrun_d;
    logic               underrun,  underrun_d;
    logic               rx_ie,     rx_ie_d;
    logic               tx_ie,     tx_ie_d;
    logic [BYTE_W-1:0]  count,     count_d;
    logic [CNT_W-1:0]   bitcnt,    bitcnt_d;
    logic [SH_W-1:0]    shift_in,  shift_in_d;
    logic [SH_W-1:0]    shift_out, shift_out_d;
    logic               miso_d;
    logic               miso_oe_d;
    logic               irq_d;

    logic               wr_data;
    logic               wr_ctrl;
    logic               wr_count;
    logic               rd_data;
    logic               do_load;
    logic               do_exit;
    logic [BYTE_W-1:0]  load_byte;
    logic [BYTE_W-1:0]  rx_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rx_buf    <= '0;
            tx_buf    <= '0;
            rx_full   <= 1'b0;
            tx_empty  <= 1'b1;
            overrun   <= 1'b0;
            underrun  <= 1'b0;
            rx_ie     <= 1'b0;
            tx_ie     <= 1'b0;
            count     <= '0;
            bitcnt    <= '0;
            shift_in  <= '0;
            shift_out <= '0;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            irq       <= 1'b0;
        end else begin
            state     <= state_d;
            rx_buf    <= rx_buf_d;
            tx_buf    <= tx_buf_d;
            rx_full   <= rx_full_d;
            tx_empty  <= tx_empty_d;
            overrun   <= overrun_d;
            underrun  <= underrun_d;
            rx_ie     <= rx_ie_d;
            tx_ie     <= tx_ie_d;
            count     <= count_d;
            bitcnt    <= bitcnt_d;
            shift_in  <= shift_in_d;
            shift_out <= shift_out_d;
            miso      <= miso_d;
            miso_oe   <= miso_oe_d;
            irq       <= irq_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state: CPU effects first, then frame FSM so that same-cycle
    // SPI events see the CPU-updated flags and buffers.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state;
        rx_buf_d    = rx_buf;
        tx_buf_d    = tx_buf;
        rx_full_d   = rx_full;
        tx_empty_d  = tx_empty;
        overrun_d   = overrun;
        underrun_d  = underrun;
        rx_ie_d     = rx_ie;
        tx_ie_d     = tx_ie;
        count_d     = count;
        bitcnt_d    = bitcnt;
        shift_in_d  = shift_in;
        shift_out_d = shift_out;
        miso_d      = miso;
        miso_oe_d   = miso_oe;
        do_load     = 1'b0;
        do_exit     = 1'b0;
        load_byte   = IDLE_FILL;
        rx_byte     = {shift_in, mosi_s};

        wr_data  = cs & ~rw & (AD == ADDR_DATA);
        wr_ctrl  = cs & ~rw & (AD == ADDR_CTRL);
        wr_count = cs & ~rw & (AD == ADDR_COUNT);
        rd_data  = cs &  rw & (AD == ADDR_DATA);

        // CPU bus side
        if (wr_data) begin
            tx_buf_d   = DI;
            tx_empty_d = 1'b0;
        end
        if (wr_ctrl) begin
            rx_ie_d = DI[0];
            tx_ie_d = DI[1];
            if (DI[6]) begin
                overrun_d  = 1'b0;
                underrun_d = 1'b0;
            end
            if (DI[7]) begin
                tx_empty_d = 1'b1;
            end
        end
        if (wr_count) begin
            count_d = '0;
        end
        if (rd_data) begin
            rx_full_d = 1'b0;
        end

        // Frame FSM
        case (state)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ss_s) begin
                    do_exit = 1'b1;
                end else begin
                    do_load = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (ss_s) begin
                    do_exit = 1'b1;
                end else if (sck_rise && (bitcnt != CNT_W'(8))) begin
                    shift_in_d = rx_byte[SH_W-1:0];
                    bitcnt_d   = bitcnt + CNT_W'(1);
                    // Byte complete on the 8th rising edge
                    if (bitcnt == CNT_W'(7)) begin
                        if (!rx_full_d) begin
                            rx_buf_d  = rx_byte;
                            rx_full_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                        if (!wr_count) begin
                            count_d = count + BYTE_W'(1);
                        end
                    end
                end else if (sck_fall && (bitcnt != '0)) begin
                    if (bitcnt == CNT_W'(8)) begin
                        do_load = 1'b1;
                    end else begin
                        miso_d      = shift_out[SH_W-1];
                        shift_out_d = {shift_out[SH_W-2:0], 1'b0};
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Load next TX byte (frame start or byte boundary); bit 7 goes out now
        if (do_load) begin
            load_byte   = tx_empty_d ? IDLE_FILL : tx_buf_d;
            underrun_d  = underrun_d | tx_empty_d;
            tx_empty_d  = 1'b1;
            shift_out_d = load_byte[SH_W-1:0];
            miso_d      = load_byte[BYTE_W-1];
            miso_oe_d   = 1'b1;
            bitcnt_d    = '0;
        end

        // Slave select released: drop any partial byte and release miso
        if (do_exit) begin
            state_d   = ST_IDLE;
            miso_d    = 1'b0;
            miso_oe_d = 1'b0;
            bitcnt_d  = '0;
        end

        irq_d = (rx_ie & (rx_full | overrun)) | (tx_ie & tx_empty);
    end

    // ------------------------------------------------------------------
    // Register read mux
    // ------------------------------------------------------------------
    always_comb begin
        DO = '0;
        case (AD)
            ADDR_DATA:   DO = rx_buf;
            ADDR_STATUS: DO = {irq, 2'b00, ~ss_s, underrun, overrun, tx_empty, rx_full};
            ADDR_CTRL:   DO = {6'b000000, tx_ie, rx_ie};
            ADDR_COUNT:  DO = count;
            default:     DO = '0;
        endcase
    end

endmodule

// File: tb/tb_spi_slaveio.sv
// Testbench for spi_slaveio: a bus master and an SPI master drive the DUT;
// expected values come from a transaction-level model and are matched by a
// scoreboard monitor against observed read data, received bytes and pins.
`timescale 1ns/1ps
module tb_spi_slaveio;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] AD = 3'd0;
    logic [7:0] DI = 8'h00;
    logic [7:0] DO;
    logic       rw = 1'b1;
    logic       cs = 1'b0;
    logic       irq;
    logic       ssel_n = 1'b1;
    logic       sck = 1'b0;
    logic       mosi = 1'b0;
    logic       miso;
    logic       miso_oe;

    spi_slaveio #(.IDLE_FILL(8'hFF), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs),
        .irq(irq), .ssel_n(ssel_n), .sck(sck), .mosi(mosi), .miso(miso), .miso_oe(miso_oe)
    );

    always #5 clk = ~clk;

    // Scoreboard
    logic [7:0] exp_q[$];
    logic [7:0] act_q[$];
    string      name_q[$];
    int         checks = 0;
    int         errors = 0;
    int         half = 12;

    always @(negedge clk) begin
        while (exp_q.size() != 0 && act_q.size() != 0) begin
            logic [7:0] e;
            logic [7:0] a;
            string      n;
            e = exp_q.pop_front();
            a = act_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got %02h expected %02h at %0t", n, a, e, $time);
            end
        end
    end

    task automatic push_exp(input string n, input logic [7:0] v);
        exp_q.push_back(v);
        name_q.push_back(n);
    endtask

    task automatic push_act(input logic [7:0] v);
        act_q.push_back(v);
    endtask

    // Reference model (transaction level)
    bit       m_tx_full, m_rx_full, m_ovr, m_und, m_rxie, m_txie;
    logic [7:0] m_tx, m_rx;
    int       m_cnt;

    task automatic model_reset();
        m_tx_full = 0; m_rx_full = 0; m_ovr = 0; m_und = 0; m_rxie = 0; m_txie = 0;
        m_tx = 8'h00; m_rx = 8'h00; m_cnt = 0;
    endtask

    function automatic bit m_irq();
        return (m_rxie && (m_rx_full || m_ovr)) || (m_txie && !m_tx_full);
    endfunction

    function automatic logic [7:0] m_status(input bit ss_low);
        logic [7:0] s;
        s = 8'h00;
        s[0] = m_rx_full;
        s[1] = !m_tx_full;
        s[2] = m_ovr;
        s[3] = m_und;
        s[4] = ss_low;
        s[7] = m_irq();
        return s;
    endfunction

    function automatic logic [7:0] model_load();
        logic [7:0] b;
        if (m_tx_full) begin
            b = m_tx;
            m_tx_full = 0;
        end else begin
            b = 8'hFF;
            m_und = 1;
        end
        return b;
    endfunction

    task automatic model_rx(input logic [7:0] b);
        if (m_rx_full) m_ovr = 1;
        else begin
            m_rx = b;
            m_rx_full = 1;
        end
        m_cnt = (m_cnt + 1) % 256;
    endtask

    // Bus and pin helpers (all called aligned to posedge+1)
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
        AD = a; DI = d; rw = 1'b0; cs = 1'b1;
        @(posedge clk); #1;
        cs = 1'b0; rw = 1'b1;
        case (a)
            3'd0: begin m_tx = d; m_tx_full = 1; end
            3'd2: begin
                m_rxie = d[0]; m_txie = d[1];
                if (d[6]) begin m_ovr = 0; m_und = 0; end
                if (d[7]) m_tx_full = 0;
            end
            3'd3: m_cnt = 0;
            default: ;
        endcase
        tick(2);
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [7:0] d);
        AD = a; rw = 1'b1; cs = 1'b1;
        @(negedge clk);
        d = DO;
        @(posedge clk); #1;
        cs = 1'b0;
        if (a == 3'd0) m_rx_full = 0;
        tick(1);
    endtask

    task automatic check_read(input string n, input logic [2:0] a, input logic [7:0] e);
        logic [7:0] d;
        push_exp(n, e);
        cpu_read(a, d);
        push_act(d);
    endtask

    task automatic check_pin(input string n, input logic e, input logic a);
        push_exp(n, {7'b0, e});
        push_act({7'b0, a});
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ssel_n = 1'b1; sck = 1'b0; mosi = 1'b0; cs = 1'b0; rw = 1'b1;
        tick(3);
        rst_n = 1'b1;
        model_reset();
        tick(2);
    endtask

    // SPI master
    task automatic spi_start();
        sck = 1'b0;
        ssel_n = 1'b0;
        tick(12);
    endtask

    // One byte; the last byte of a frame leaves sck high (no trailing falling
    // edge), and rd_on_last issues a DATA read on the clk where the 8th synced
    // rising edge completes the byte.
    task automatic spi_byte(input logic [7:0] tx, input bit last, input bit rd_on_last);
        logic [7:0] rx;
        logic [7:0] rdv;
        logic [7:0] rd_exp;
        push_exp("miso_byte", model_load());
        rx = 8'h00;
        rdv = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            tick(half);
            sck = 1'b1;
            rx = {rx[6:0], miso};
            if (i == 0 && rd_on_last) begin
                tick(2);
                AD = 3'd0; rw = 1'b1; cs = 1'b1;
                @(negedge clk);
                rdv = DO;
                @(posedge clk); #1;
                cs = 1'b0;
                tick(half - 3);
            end else begin
                tick(half);
            end
            if (!(last && i == 0)) sck = 1'b0;
        end
        push_act(rx);
        if (rd_on_last) begin
            rd_exp = m_rx;
            m_rx_full = 0;
            model_rx(tx);
            push_exp("data_rd_at_complete", rd_exp);
            push_act(rdv);
        end else begin
            model_rx(tx);
        end
    endtask

    task automatic spi_end();
        tick(half);
        ssel_n = 1'b1;
        tick(6);
        sck = 1'b0;
        mosi = 1'b0;
        tick(6);
    endtask

    task automatic spi_partial_rises(input int nbits);
        void'(model_load());
        for (int i = 0; i < nbits; i++) begin
            mosi = 1'($urandom_range(1, 0));
            tick(half);
            sck = 1'b1;
            tick(half);
            if (i != nbits - 1) sck = 1'b0;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r1;
        logic [7:0] r2;
        int         nb;
        int         cnt_before;

        model_reset();
        do_reset();

        // Reset values
        for (int a = 0; a < 8; a++) begin
            check_read("reset_DO", 3'(a), m_status(0) & ((a == 1) ? 8'hFF : 8'h00));
        end
        check_pin("reset_irq", 1'b0, irq);
        check_pin("reset_miso", 1'b0, miso);
        check_pin("reset_miso_oe", 1'b0, miso_oe);

        // Basic exchange: A5 out, 3C in
        cpu_write(3'd0, 8'hA5);
        spi_start();
        check_pin("miso_oe_active", 1'b1, miso_oe);
        spi_byte(8'h3C, 1, 0);
        check_read("status_ss_low", 3'd1, 8'h13);
        check_read("count_one", 3'd3, 8'(m_cnt));
        check_read("rx_3c", 3'd0, 8'h3C);
        spi_end();

        // Overrun with rx_ie
        cpu_write(3'd2, 8'h01);
        spi_start();
        spi_byte(8'h11, 0, 0);
        spi_byte(8'h22, 1, 0);
        spi_end();
        check_pin("irq_overrun", m_irq(), irq);
        check_read("status_overrun", 3'd1, m_status(0));
        cpu_write(3'd2, 8'h41);
        check_pin("irq_after_clear", 1'b1, irq);
        check_read("status_cleared", 3'd1, m_status(0));
        check_read("rx_first_kept", 3'd0, 8'h11);
        tick(1);
        check_pin("irq_after_read", m_irq(), irq);

        // Underrun and tx_ie after reset
        do_reset();
        cpu_write(3'd2, 8'h02);
        check_pin("irq_tx_ie", 1'b1, irq);
        spi_start();
        spi_byte(8'($urandom), 1, 0);
        spi_end();
        check_read("status_underrun", 3'd1, m_status(0));

        // Frame aborted after 5 bits
        cpu_write(3'd2, 8'h40);
        check_read("rx_drain", 3'd0, m_rx);
        cpu_write(3'd0, 8'h5A);
        cnt_before = m_cnt;
        spi_start();
        spi_partial_rises(5);
        check_pin("miso_oe_mid", 1'b1, miso_oe);
        ssel_n = 1'b1;
        tick(4);
        check_pin("abort_miso_oe", 1'b0, miso_oe);
        check_pin("abort_miso", 1'b0, miso);
        sck = 1'b0;
        tick(6);
        check_read("abort_status", 3'd1, m_status(0));
        check_read("abort_count", 3'd3, 8'(cnt_before));

        // DATA read on the exact clk of byte completion
        r1 = 8'($urandom);
        r2 = 8'($urandom);
        spi_start();
        spi_byte(r1, 0, 0);
        spi_byte(r2, 1, 1);
        spi_end();
        check_read("status_rd_race", 3'd1, m_status(0));
        check_read("rx_rd_race", 3'd0, r2);

        // Randomised frames
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(1, 0) == 1) cpu_write(3'd0, 8'($urandom));
            if ($urandom_range(3, 0) == 0)
                cpu_write(3'd2, 8'($urandom_range(3, 0)) | (($urandom_range(1, 0) == 1) ? 8'h40 : 8'h00)
                          | (($urandom_range(4, 0) == 0) ? 8'h80 : 8'h00));
            if ($urandom_range(7, 0) == 0) cpu_write(3'd3, 8'($urandom));
            nb = $urandom_range(3, 1);
            spi_start();
            for (int k = 0; k < nb; k++) spi_byte(8'($urandom), k == nb - 1, 0);
            check_read("rnd_status_ss", 3'd1, m_status(1));
            spi_end();
            check_pin("rnd_irq", m_irq(), irq);
            if ($urandom_range(1, 0) == 1) check_read("rnd_data", 3'd0, m_rx);
            check_read("rnd_count", 3'd3, 8'(m_cnt));
        end

        // 256 bytes wrap COUNT to zero
        cpu_write(3'd3, 8'h00);
        half = 4;
        spi_start();
        for (int k = 0; k < 256; k++) spi_byte(8'($urandom), k == 255, 0);
        check_read("count_wrap", 3'd3, 8'h00);
        spi_end();
        half = 12;

        // Reset asserted mid-byte
        cpu_write(3'd2, 8'h03);
        cpu_write(3'd0, 8'hC3);
        spi_start();
        spi_partial_rises(3);
        rst_n = 1'b0;
        tick(2);
        check_pin("rst_mid_miso", 1'b0, miso);
        check_pin("rst_mid_miso_oe", 1'b0, miso_oe);
        check_pin("rst_mid_irq", 1'b0, irq);
        check_read("rst_mid_status", 3'd1, 8'h02);
        check_read("rst_mid_ctrl", 3'd2, 8'h00);
        check_read("rst_mid_data", 3'd0, 8'h00);
        ssel_n = 1'b1;
        sck = 1'b0;
        tick(2);
        rst_n = 1'b1;
        model_reset();
        tick(4);
        check_read("post_rst_status", 3'd1, m_status(0));

        tick(3);
        if (exp_q.size() != 0 || act_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d actual expected %0d pending", act_q.size(), exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
